// File: rtl/oled_pkg.sv
// Shared definitions for the OLED power sequencer.
//   state_t        : sequencer state encoding
//   out_t          : registered output bundle (everything except the optional fault flag)
//   CMD_DISPLAY_ON / CMD_DISPLAY_OFF : panel command bytes
//   max2, is_busy, decode_outputs    : small helpers shared by the top level
package oled_pkg;

  typedef enum logic [3:0] {
    ST_OFF      = 4'd0,
    ST_PMOD_UP  = 4'd1,
    ST_RES_LO   = 4'd2,
    ST_RES_HI   = 4'd3,
    ST_VCC_UP   = 4'd4,
    ST_DISP_ON  = 4'd5,
    ST_SETTLE   = 4'd6,
    ST_READY    = 4'd7,
    ST_DISP_OFF = 4'd8,
    ST_VCC_DN   = 4'd9,
    ST_FAULT    = 4'd10
  } state_t;

  localparam logic [7:0] CMD_DISPLAY_ON  = 8'hAF;
  localparam logic [7:0] CMD_DISPLAY_OFF = 8'hAE;

  typedef struct packed {
    logic       pmoden;
    logic       vccen;
    logic       res_n;
    logic       cmd_valid;
    logic [7:0] cmd_byte;
    logic       ready;
    logic       busy;
  } out_t;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic is_busy(input state_t s);
    return !((s == ST_OFF) || (s == ST_READY) || (s == ST_FAULT));
  endfunction

  // Output values that hold for the whole time the FSM sits in state s.
  // OFF and FAULT both map to the all-zero (panel fully unpowered) bundle.
  function automatic out_t decode_outputs(input state_t s);
    out_t o;
    o = '0;
    case (s)
      ST_PMOD_UP: begin
        o.pmoden = 1'b1;
        o.res_n  = 1'b1;
      end
      ST_RES_LO: begin
        o.pmoden = 1'b1;
      end
      ST_RES_HI: begin
        o.pmoden = 1'b1;
        o.res_n  = 1'b1;
      end
      ST_VCC_UP, ST_SETTLE: begin
        o.pmoden = 1'b1;
        o.vccen  = 1'b1;
        o.res_n  = 1'b1;
      end
      ST_DISP_ON: begin
        o.pmoden    = 1'b1;
        o.vccen     = 1'b1;
        o.res_n     = 1'b1;
        o.cmd_valid = 1'b1;
        o.cmd_byte  = CMD_DISPLAY_ON;
      end
      ST_READY: begin
        o.pmoden = 1'b1;
        o.vccen  = 1'b1;
        o.res_n  = 1'b1;
        o.ready  = 1'b1;
      end
      ST_DISP_OFF: begin
        o.pmoden    = 1'b1;
        o.vccen     = 1'b1;
        o.res_n     = 1'b1;
        o.cmd_valid = 1'b1;
        o.cmd_byte  = CMD_DISPLAY_OFF;
      end
      ST_VCC_DN: begin
        o.pmoden = 1'b1;
        o.res_n  = 1'b1;
      end
      default: o = '0;
    endcase
    o.busy = is_busy(s);
    return o;
  endfunction

endpackage

// File: rtl/oled_tick_gen.sv
// Delay tick generator: emits a one-cycle tick every DIV enabled cycles.
//   clk, rst_n : clock, async active-low reset
//   en         : count enable; the divider is held at zero while low
//   clr        : synchronous clear (restart the divider from zero)
//   tick       : one-cycle pulse on the DIV-th enabled cycle
module oled_tick_gen #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = $clog2(DIV);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == W'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || !en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/oled_power_sequencer.sv
// OLED panel power-up / power-down sequencer.
// Optional feature macro: OLED_SEQ_CMD_TIMEOUT_EN (command-acknowledge timeout -> FAULT, adds o_FAULT).
//
//   state     | meaning
//   OFF       | panel unpowered, waiting for i_START_ON
//   PMOD_UP   | logic supply on, T_PMOD ticks
//   RES_LO    | panel reset asserted, T_RES ticks
//   RES_HI    | panel reset released, T_RES ticks
//   VCC_UP    | panel VCC on, T_VCC ticks
//   DISP_ON   | display-on command offered until i_CMD_DONE
//   SETTLE    | T_VCC ticks after display on
//   READY     | panel up, waiting for i_START_OFF
//   DISP_OFF  | display-off command offered until i_CMD_DONE
//   VCC_DN    | VCC off, T_OFF ticks before logic supply drops
//   FAULT     | command never acknowledged; everything off until reset
//
// Ports: i_CLK, i_RST_N (async active-low), i_START_ON, i_START_OFF, i_CMD_DONE in;
//        o_CMD_VALID, o_CMD_BYTE[7:0], o_PMODEN, o_VCCEN, o_RES_N, o_READY, o_BUSY
//        [, o_FAULT] out. All outputs are registered.
module oled_power_sequencer
  import oled_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned TICK_HZ  = 1000,
  parameter int unsigned T_PMOD   = 20,
  parameter int unsigned T_RES    = 3,
  parameter int unsigned T_VCC    = 100,
  parameter int unsigned T_OFF    = 400,
  parameter int unsigned T_CMD_TO = 10
) (
  input  logic       i_CLK,
  input  logic       i_RST_N,
  input  logic       i_START_ON,
  input  logic       i_START_OFF,
  input  logic       i_CMD_DONE,
  output logic       o_CMD_VALID,
  output logic [7:0] o_CMD_BYTE,
  output logic       o_PMODEN,
  output logic       o_VCCEN,
  output logic       o_RES_N,
  output logic       o_READY,
  output logic       o_BUSY
`ifdef OLED_SEQ_CMD_TIMEOUT_EN
  ,
  output logic       o_FAULT
`endif
);

  localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned T_MAX = max2(max2(max2(T_PMOD, T_RES), max2(T_VCC, T_OFF)), T_CMD_TO);
  localparam int unsigned CW    = $clog2(T_MAX + 1);

  state_t        state;
  state_t        next_state;
  logic          tick;
  logic          clr;
  logic [CW-1:0] tick_cnt;
  logic [CW-1:0] wait_last;
  logic          wait_done;
  out_t          out_q;

  // Any state change restarts both the divider and the tick counter, so each
  // wait measures exactly N*DIV cycles from the first cycle in the new state.
  assign clr = (next_state != state);

  oled_tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk   (i_CLK),
    .rst_n (i_RST_N),
    .en    (is_busy(state)),
    .clr   (clr),
    .tick  (tick)
  );

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      tick_cnt <= '0;
    end else if (clr) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_comb begin
    wait_last = '0;
    case (state)
      ST_PMOD_UP:              wait_last = CW'(T_PMOD - 1);
      ST_RES_LO, ST_RES_HI:    wait_last = CW'(T_RES - 1);
      ST_VCC_UP, ST_SETTLE:    wait_last = CW'(T_VCC - 1);
      ST_VCC_DN:               wait_last = CW'(T_OFF - 1);
      ST_DISP_ON, ST_DISP_OFF: wait_last = CW'(T_CMD_TO - 1);
      default:                 wait_last = '0;
    endcase
  end

  assign wait_done = tick && (tick_cnt == wait_last);

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state <= ST_OFF;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_OFF:     if (i_START_ON) next_state = ST_PMOD_UP;
      ST_PMOD_UP: if (wait_done)  next_state = ST_RES_LO;
      ST_RES_LO:  if (wait_done)  next_state = ST_RES_HI;
      ST_RES_HI:  if (wait_done)  next_state = ST_VCC_UP;
      ST_VCC_UP:  if (wait_done)  next_state = ST_DISP_ON;
      ST_DISP_ON: begin
        if (i_CMD_DONE) next_state = ST_SETTLE;
`ifdef OLED_SEQ_CMD_TIMEOUT_EN
        else if (wait_done) next_state = ST_FAULT;
`endif
      end
      ST_SETTLE:  if (wait_done)   next_state = ST_READY;
      ST_READY:   if (i_START_OFF) next_state = ST_DISP_OFF;
      ST_DISP_OFF: begin
        if (i_CMD_DONE) next_state = ST_VCC_DN;
`ifdef OLED_SEQ_CMD_TIMEOUT_EN
        else if (wait_done) next_state = ST_FAULT;
`endif
      end
      ST_VCC_DN:  if (wait_done) next_state = ST_OFF;
      ST_FAULT:   next_state = ST_FAULT;
      default:    next_state = ST_OFF;
    endcase
  end

  // Outputs are registered from next_state so they line up with the state
  // register: the new state's outputs appear in its first cycle.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      out_q <= '0;
    end else begin
      out_q <= decode_outputs(next_state);
    end
  end

`ifdef OLED_SEQ_CMD_TIMEOUT_EN
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      o_FAULT <= 1'b0;
    end else begin
      o_FAULT <= (next_state == ST_FAULT);
    end
  end
`endif

  assign o_PMODEN    = out_q.pmoden;
  assign o_VCCEN     = out_q.vccen;
  assign o_RES_N     = out_q.res_n;
  assign o_CMD_VALID = out_q.cmd_valid;
  assign o_CMD_BYTE  = out_q.cmd_byte;
  assign o_READY     = out_q.ready;
  assign o_BUSY      = out_q.busy;

endmodule

// File: tb/tb_oled_power_sequencer.sv
// Scoreboard bench for oled_power_sequencer (DIV=10).
// Stimulus pushes the expected output-change events (cycle, output vector);
// a negedge monitor pops one entry on each observed output change.
module tb_oled_power_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start_on;
  logic       start_off;
  logic       cmd_done;
  logic       cmd_valid;
  logic [7:0] cmd_byte;
  logic       pmoden;
  logic       vccen;
  logic       res_n;
  logic       ready;
  logic       busy;
`ifdef OLED_SEQ_CMD_TIMEOUT_EN
  logic       fault;
`endif

  oled_power_sequencer #(
    .CLK_HZ(1000), .TICK_HZ(100),
    .T_PMOD(2), .T_RES(1), .T_VCC(3), .T_OFF(4), .T_CMD_TO(2)
  ) dut (
    .i_CLK       (clk),
    .i_RST_N     (rst_n),
    .i_START_ON  (start_on),
    .i_START_OFF (start_off),
    .i_CMD_DONE  (cmd_done),
    .o_CMD_VALID (cmd_valid),
    .o_CMD_BYTE  (cmd_byte),
    .o_PMODEN    (pmoden),
    .o_VCCEN     (vccen),
    .o_RES_N     (res_n),
    .o_READY     (ready),
    .o_BUSY      (busy)
`ifdef OLED_SEQ_CMD_TIMEOUT_EN
    ,
    .o_FAULT     (fault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [13:0] vec;
    string       name;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [13:0] mk(input logic p, input logic v, input logic r,
                                     input logic cv, input logic [7:0] b,
                                     input logic rd, input logic bs);
    return {p, v, r, cv, b, rd, bs};
  endfunction

  function automatic logic [13:0] outs();
    return {pmoden, vccen, res_n, cmd_valid, cmd_byte, ready, busy};
  endfunction

  localparam logic [13:0] V_OFF      = 14'h0000;
  logic [13:0] v_pmod, v_reslo, v_reshi, v_vccup, v_dispon, v_settle, v_ready, v_dispoff, v_vccdn;

  initial begin
    v_pmod    = mk(1, 0, 1, 0, 8'h00, 0, 1);
    v_reslo   = mk(1, 0, 0, 0, 8'h00, 0, 1);
    v_reshi   = mk(1, 0, 1, 0, 8'h00, 0, 1);
    v_vccup   = mk(1, 1, 1, 0, 8'h00, 0, 1);
    v_dispon  = mk(1, 1, 1, 1, 8'hAF, 0, 1);
    v_settle  = mk(1, 1, 1, 0, 8'h00, 0, 1);
    v_ready   = mk(1, 1, 1, 0, 8'h00, 1, 0);
    v_dispoff = mk(1, 1, 1, 1, 8'hAE, 0, 1);
    v_vccdn   = mk(1, 0, 1, 0, 8'h00, 0, 1);
  end

  task automatic push(input int c, input logic [13:0] v, input string n);
    exp_t e;
    e.cyc  = c;
    e.vec  = v;
    e.name = n;
    q.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_now(input string n, input logic [13:0] act, input logic [13:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, req);
    end
  endtask

  // Monitor: every change of the output vector must match the next queued event.
  logic [13:0] prev = 14'h0000;
  always @(negedge clk) begin
    logic [13:0] now;
    exp_t e;
    now = outs();
    if (now !== prev) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_change: cycle %0d outputs %h (was %h)", cyc, now, prev);
      end else begin
        e = q.pop_front();
        total += 2;
        if (now !== e.vec) begin
          bad++;
          $display("FAIL %s_value: got %h expected %h", e.name, now, e.vec);
        end
        if (cyc != e.cyc) begin
          bad++;
          $display("FAIL %s_cycle: got %0d expected %0d", e.name, cyc, e.cyc);
        end
      end
    end
    prev = now;
  end

  int t, u, v, w;
`ifdef OLED_SEQ_CMD_TIMEOUT_EN
  int x;
`endif

  initial begin
    rst_n     = 1'b0;
    start_on  = 1'b0;
    start_off = 1'b0;
    cmd_done  = 1'b0;
    wait_until(3);
    check_now("reset_state", outs(), V_OFF);
    rst_n = 1'b1;
    wait_until(6);

    // Power-up, with a stray start_off in PMOD_UP and a stray cmd_done in VCC_UP.
    t = cyc;
    push(t + 1,   v_pmod,   "pmod_up");
    push(t + 21,  v_reslo,  "res_lo");
    push(t + 31,  v_reshi,  "res_hi");
    push(t + 41,  v_vccup,  "vcc_up");
    push(t + 71,  v_dispon, "disp_on");
    push(t + 76,  v_settle, "settle");
    push(t + 106, v_ready,  "ready");
    start_on = 1'b1;
    wait_until(t + 1);   start_on  = 1'b0;
    wait_until(t + 5);   start_off = 1'b1;
    wait_until(t + 6);   start_off = 1'b0;
    wait_until(t + 50);  cmd_done  = 1'b1;
    wait_until(t + 51);  cmd_done  = 1'b0;
    wait_until(t + 75);  cmd_done  = 1'b1;
    wait_until(t + 76);  cmd_done  = 1'b0;
    wait_until(t + 108); start_on  = 1'b1;
    wait_until(t + 109); start_on  = 1'b0;
    wait_until(t + 115);

    // Power-down with both requests raised together.
    u = cyc;
    push(u + 1,  v_dispoff, "disp_off");
    push(u + 4,  v_vccdn,   "vcc_dn");
    push(u + 44, V_OFF,     "off");
    start_on  = 1'b1;
    start_off = 1'b1;
    wait_until(u + 1); start_on = 1'b0; start_off = 1'b0;
    wait_until(u + 3); cmd_done = 1'b1;
    wait_until(u + 4); cmd_done = 1'b0;
    wait_until(u + 50);

    // Reset during VCC_UP, request held through reset, then restart.
    v = cyc;
    push(v + 1,  v_pmod,  "pmod_up2");
    push(v + 21, v_reslo, "res_lo2");
    push(v + 31, v_reshi, "res_hi2");
    push(v + 41, v_vccup, "vcc_up2");
    push(v + 45, V_OFF,   "reset_mid");
    start_on = 1'b1;
    wait_until(v + 1); start_on = 1'b0;
    wait_until(v + 45);
    #1;
    rst_n = 1'b0;
    #1;
    check_now("async_reset", outs(), V_OFF);
    start_on = 1'b1;
    wait_until(v + 47); start_on = 1'b0;
    wait_until(v + 48); rst_n = 1'b1;
    wait_until(v + 52);
    w = cyc;
    push(w + 1,  v_pmod,  "pmod_up3");
    push(w + 21, v_reslo, "res_lo3");
    start_on = 1'b1;
    wait_until(w + 1); start_on = 1'b0;
    wait_until(w + 25);

`ifdef OLED_SEQ_CMD_TIMEOUT_EN
    // Display-on command never acknowledged.
    push(cyc, V_OFF, "reset_pre_fault");
    #1;
    rst_n = 1'b0;
    wait_until(cyc + 2); rst_n = 1'b1;
    wait_until(cyc + 2);
    x = cyc;
    push(x + 1,  v_pmod,   "pmod_up4");
    push(x + 21, v_reslo,  "res_lo4");
    push(x + 31, v_reshi,  "res_hi4");
    push(x + 41, v_vccup,  "vcc_up4");
    push(x + 71, v_dispon, "disp_on4");
    push(x + 91, V_OFF,    "fault");
    start_on = 1'b1;
    wait_until(x + 1); start_on = 1'b0;
    wait_until(x + 80);
    check_now("fault_low_in_disp_on", {13'h0, fault}, 14'h0000);
    wait_until(x + 95); start_on = 1'b1;
    wait_until(x + 96); start_on = 1'b0;
    wait_until(x + 110);
    check_now("fault_flag", {13'h0, fault}, 14'h0001);
`endif

    wait_until(cyc + 3);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL missing_events: got %0d pending, expected 0 (next %s at cycle %0d)",
               q.size(), q[0].name, q[0].cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/oled_power_sequencer.md
OLED_POWER_SEQUENCER -- requirements
Module: oled_power_sequencer

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000: system clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 1000: delay tick rate; DIV = CLK_HZ/TICK_HZ cycles per tick, DIV SHALL be >= 2.
REQ-003 Parameters T_PMOD, T_RES, T_VCC, T_OFF, T_CMD_TO, defaults 20, 3, 100, 400, 10: delays in ticks, each >= 1.
REQ-004 i_CLK  in  1  sole clock; all logic on rising edge.
REQ-005 i_RST_N  in  1  asynchronous, active-low reset.
REQ-006 i_START_ON  in  1  level-sampled request to run the power-up sequence.
REQ-007 i_START_OFF  in  1  level-sampled request to run the power-down sequence.
REQ-008 i_CMD_DONE  in  1  one-cycle pulse from the SPI byte sender: byte transmitted.
REQ-009 o_CMD_VALID  out  1  command byte request to the SPI byte sender.
REQ-010 o_CMD_BYTE  out  8  command byte, stable while o_CMD_VALID=1.
REQ-011 o_PMODEN, o_VCCEN, o_RES_N  out  1 each  panel logic supply, panel VCC, panel reset (active low).
REQ-012 o_READY  out  1  panel powered and display on; o_BUSY  out  1  sequence in progress.

Function
REQ-013 States SHALL be OFF, PMOD_UP, RES_LO, RES_HI, VCC_UP, DISP_ON, SETTLE, READY, DISP_OFF, VCC_DN, FAULT.
REQ-014 OFF: i_START_ON=1 -> PMOD_UP; i_START_OFF ignored.
REQ-015 PMOD_UP: o_PMODEN=1, wait T_PMOD ticks -> RES_LO.
REQ-016 RES_LO: o_RES_N=0, wait T_RES ticks -> RES_HI; RES_HI: o_RES_N=1, wait T_RES ticks -> VCC_UP.
REQ-017 VCC_UP: o_VCCEN=1, wait T_VCC ticks -> DISP_ON.
REQ-018 DISP_ON: o_CMD_VALID=1, o_CMD_BYTE=8'hAF; on i_CMD_DONE -> SETTLE.
REQ-019 SETTLE: wait T_VCC ticks -> READY; READY: o_READY=1, o_BUSY=0.
REQ-020 READY: i_START_OFF=1 -> DISP_OFF (off wins if i_START_ON also high); i_START_ON alone ignored.
REQ-021 DISP_OFF: o_CMD_VALID=1, o_CMD_BYTE=8'hAE; on i_CMD_DONE -> VCC_DN.
REQ-022 VCC_DN: o_VCCEN=0, wait T_OFF ticks; then o_PMODEN=0 -> OFF.
REQ-023 i_START_ON/i_START_OFF SHALL be ignored in all states except as in REQ-014/REQ-020.
REQ-024 A wait of N ticks SHALL last exactly N*DIV cycles from state entry to transition; tick counter and divider cleared on every state change.
REQ-025 o_CMD_VALID SHALL deassert in the cycle after i_CMD_DONE is sampled; i_CMD_DONE outside DISP_ON/DISP_OFF ignored.
REQ-026 o_BUSY=1 in every state except OFF, READY, FAULT.
REQ-027 All outputs SHALL be registered; state changes take one cycle after the qualifying condition.

Reset
REQ-028 i_RST_N=0 SHALL immediately force OFF: o_PMODEN=0, o_VCCEN=0, o_RES_N=0, o_CMD_VALID=0, o_CMD_BYTE=8'h00, o_READY=0, o_BUSY=0, counters 0.
REQ-029 Reset mid-sequence SHALL abandon the sequence; no pending request survives reset.

Configuration
REQ-030 Macro OLED_SEQ_CMD_TIMEOUT_EN defined: in DISP_ON/DISP_OFF, no i_CMD_DONE within T_CMD_TO ticks -> FAULT; FAULT drives o_VCCEN=0, o_PMODEN=0, o_RES_N=0, o_CMD_VALID=0, exits only by reset; extra output o_FAULT (1 bit, 1 in FAULT).
REQ-031 Macro undefined: DISP_ON/DISP_OFF wait indefinitely; FAULT unreachable; no o_FAULT port.

Structure
REQ-032 Shared package oled_pkg SHALL hold state encoding and command constants (display on 8'hAF, display off 8'hAE).
REQ-033 Sub-module oled_tick_gen: enable/clear input, one-cycle tick every DIV enabled cycles, count cleared when disabled.

Verification (CLK_HZ=1000, TICK_HZ=100 so DIV=10; T_PMOD=2, T_RES=1, T_VCC=3, T_OFF=4, T_CMD_TO=2)
REQ-034 i_START_ON pulse in OFF -> o_PMODEN rises; o_RES_N low exactly 10 cycles; o_VCCEN rises 40 cycles after o_PMODEN; o_CMD_VALID with 8'hAF.
REQ-035 i_CMD_DONE 5 cycles after valid -> o_CMD_VALID drops next cycle; o_READY=1 exactly 30 cycles later.
REQ-036 READY, i_START_ON=i_START_OFF=1 same cycle -> DISP_OFF with 8'hAE; after done, o_VCCEN=0, o_PMODEN=0 40 cycles later, state OFF.
REQ-037 i_RST_N low during VCC_UP -> all outputs at reset values asynchronously; i_START_ON after release restarts at PMOD_UP.
REQ-038 OLED_SEQ_CMD_TIMEOUT_EN defined, i_CMD_DONE withheld in DISP_ON -> FAULT after 20 cycles, o_FAULT=1, o_VCCEN=0, i_START_ON ignored.
REQ-039 i_START_OFF in PMOD_UP and stray i_CMD_DONE in VCC_UP -> no effect on sequence timing.
